// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
//
// Shares the second read port of the dual-port boot ROM between two requesters:
//   m0 = core data bus (loads from the ROM region)
//   m1 = debug / loader reader
//
// Arbitration and grant:
//   - Grants are combinational: a request can be accepted in the same cycle.
//   - When both requesters ask, they take turns (round-robin).
//   - m0 wins the first tie after reset.
//
// Address and data path:
//   - Byte addresses are converted to ROM word addresses.
//   - A misaligned access is not issued to the ROM. It returns an error
//     response instead.
//   - The ROM read data arrives one cycle after an accept. It is steered back
//     to the requester that won that accept.
//
// Optional feature: define ROM_ARB_LOCK_EN to enable lock.
//   - An accept with mN_lock=1 makes N the lock owner from the next cycle.
//   - While N owns the lock, the other requester is held off.
//   - Ownership ends in the cycle after the owner's lock input is sampled low.
//   - Without the macro, the mN_lock inputs are ignored.
//
// Parameters:
//   ADDR_WIDTH    ROM word-address bits; must match the ROM instance
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst           synchronous, active-high reset
//   mN_req        read request from requester N
//   mN_addr       byte address within the ROM (ADDR_WIDTH+2 bits)
//   mN_lock       keep-ownership request (only with ROM_ARB_LOCK_EN)
//   mN_gnt        request accepted this cycle (combinational)
//   mN_rsp_valid  one-cycle response pulse, one cycle after the accept
//   mN_rsp_err    response is a misalignment error
//   mN_rsp_data   read data (zero for an error response)
//   rom_rd_en     ROM read enable (rd_en2)
//   rom_addr      ROM word address (addr2)
//   rom_rd_data   ROM read data (rd_data2), valid one cycle after rom_rd_en
// -----------------------------------------------------------------------------
module rom_arbiter #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req,
   input  logic [ADDR_WIDTH+1:0] m0_addr,
   input  logic                  m0_lock,
   output logic                  m0_gnt,
   output logic                  m0_rsp_valid,
   output logic                  m0_rsp_err,
   output logic [31:0]           m0_rsp_data,
   input  logic                  m1_req,
   input  logic [ADDR_WIDTH+1:0] m1_addr,
   input  logic                  m1_lock,
   output logic                  m1_gnt,
   output logic                  m1_rsp_valid,
   output logic                  m1_rsp_err,
   output logic [31:0]           m1_rsp_data,
   output logic                  rom_rd_en,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [31:0]           rom_rd_data
);

   logic [1:0]            req;
   logic [1:0]            elig;
   logic [1:0]            gnt;
   logic                  accept;
   logic                  win_idx;
   logic [ADDR_WIDTH+1:0] sel_addr;
   logic                  misaligned;

   // Index of the most recently accepted requester.
   // It resets to 1 so that m0 wins the first tie.
   logic                  last_reg;

   // One valid bit per requester. Only one of them can be set in a cycle.
   logic [1:0]            rsp_valid_reg;
   logic                  rsp_err_reg;

   assign req = {m1_req, m0_req};

`ifdef ROM_ARB_LOCK_EN
   logic [1:0] lock;
   logic       own_valid_reg;
   logic       own_idx_reg;

   assign lock = {m1_lock, m0_lock};

   // Track the lock owner.
   // The owner's lock input is sampled every cycle, even when the owner is
   // idle. Seeing it low releases ownership at the next edge, so the cycle in
   // which lock is seen low still arbitrates as owned.
   always_ff @(posedge clk) begin
      if (rst) begin
         own_valid_reg <= 1'b0;
         own_idx_reg   <= 1'b0;
      end else if (own_valid_reg) begin
         if (!lock[own_idx_reg]) begin
            own_valid_reg <= 1'b0;
         end
      end else if (accept && lock[win_idx]) begin
         own_valid_reg <= 1'b1;
         own_idx_reg   <= win_idx;
      end
   end
`else
   logic unused_lock;
   assign unused_lock = m0_lock ^ m1_lock;
`endif

   // Grant logic.
   // Every grant is held at zero during reset.
   // A request only becomes eligible when no other requester owns the lock.
   // If both requesters are eligible, the one that was not granted last wins.
   always_comb begin
      elig = '0;
      gnt  = '0;
      if (!rst) begin
         elig = req;
`ifdef ROM_ARB_LOCK_EN
         if (own_valid_reg) begin
            elig[~own_idx_reg] = 1'b0;
         end
`endif
         if (elig[0] && elig[1]) begin
            if (last_reg) begin
               gnt[0] = 1'b1;
            end else begin
               gnt[1] = 1'b1;
            end
         end else begin
            gnt = elig;
         end
      end
   end

   assign m0_gnt = gnt[0];
   assign m1_gnt = gnt[1];

   // A grant is only ever given to a requester that is asking.
   // So a grant is an accept.
   assign accept  = |gnt;
   assign win_idx = gnt[1];

   assign sel_addr   = win_idx ? m1_addr : m0_addr;
   assign misaligned = (sel_addr[1:0] != 2'b00);

   // Misaligned accesses never reach the ROM.
   assign rom_rd_en = accept && !misaligned;
   assign rom_addr  = sel_addr[ADDR_WIDTH+1:2];

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_reg <= '0;
         rsp_err_reg   <= 1'b0;
         last_reg      <= 1'b1;
      end else begin
         rsp_valid_reg <= gnt;
         rsp_err_reg   <= accept && misaligned;
         if (accept) begin
            last_reg <= win_idx;
         end
      end
   end

   // Responses are masked by rst.
   // This drops a response whose accept came in the cycle just before reset.
   assign m0_rsp_valid = rsp_valid_reg[0] && !rst;
   assign m1_rsp_valid = rsp_valid_reg[1] && !rst;
   assign m0_rsp_err   = m0_rsp_valid && rsp_err_reg;
   assign m1_rsp_err   = m1_rsp_valid && rsp_err_reg;

   // ROM data is shared by both requesters; only the valid bit distinguishes
   // them. An error response returns zero instead of stale ROM output.
   assign m0_rsp_data = rsp_err_reg ? 32'h0 : rom_rd_data;
   assign m1_rsp_data = rsp_err_reg ? 32'h0 : rom_rd_data;

endmodule

// File: tb/tb_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_arbiter
//
// Testbench for rom_arbiter.
// Runs directed scenarios first, then randomized traffic.
// Every step is checked against a transaction-level reference model.
// A simple registered-read ROM model sits on the rom_* port.
// Define ROM_ARB_LOCK_EN when compiling to exercise lock behaviour.
// -----------------------------------------------------------------------------
module tb_rom_arbiter;

   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_lock, m1_req, m1_lock;
   logic [AW+1:0] m0_addr, m1_addr;
   logic          m0_gnt, m0_rsp_valid, m0_rsp_err;
   logic          m1_gnt, m1_rsp_valid, m1_rsp_err;
   logic [31:0]   m0_rsp_data, m1_rsp_data;
   logic          rom_rd_en;
   logic [AW-1:0] rom_addr;
   logic [31:0]   rom_rd_data;

   logic [31:0]   rom_mem [0:(1<<AW)-1];

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state, kept at the transaction level.
   int last_w;   // requester accepted most recently
   int owner;    // lock owner, -1 when nobody owns the lock
   bit pv;       // a response is due in the current cycle
   int pw;       // requester that response belongs to
   bit pe;       // that response is an error
   int pword;    // word address for that response

   always #5 clk = ~clk;

   // ROM model: one-cycle registered read.
   always @(posedge clk) begin
      if (rom_rd_en) begin
         rom_rd_data <= rom_mem[rom_addr];
      end
   end

   rom_arbiter #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_lock(m0_lock),
      .m0_gnt(m0_gnt), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_err(m0_rsp_err),
      .m0_rsp_data(m0_rsp_data),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_lock(m1_lock),
      .m1_gnt(m1_gnt), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_err(m1_rsp_err),
      .m1_rsp_data(m1_rsp_data),
      .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_rd_data(rom_rd_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Runs one clock cycle.
   // Inputs are driven just after the rising edge.
   // Outputs are checked on the falling edge.
   // The model advances on the next rising edge.
   task automatic step(input bit r, input bit q0, input logic [7:0] a0, input bit l0,
                       input bit q1, input logic [7:0] a1, input bit l1);
      bit          e0, e1, g0, g1, acc;
      int          win;
      logic [7:0]  a;
      logic [31:0] exp_data;

      rst = r;
      m0_req = q0; m0_addr = a0; m0_lock = l0;
      m1_req = q1; m1_addr = a1; m1_lock = l1;

      @(negedge clk);

      g0 = 1'b0;
      g1 = 1'b0;
      if (!r) begin
         e0 = q0 && (owner != 1);
         e1 = q1 && (owner != 0);
         if (e0 && e1) begin
            if (last_w == 0) g1 = 1'b1;
            else             g0 = 1'b1;
         end else begin
            g0 = e0;
            g1 = e1;
         end
      end
      acc = g0 || g1;
      win = g1 ? 1 : 0;
      a   = g1 ? a1 : a0;

      chk("m0_gnt", 32'(m0_gnt), 32'(g0));
      chk("m1_gnt", 32'(m1_gnt), 32'(g1));
      chk("rom_rd_en", 32'(rom_rd_en), 32'(acc && (a[1:0] == 2'b00)));
      if (acc && (a[1:0] == 2'b00)) begin
         chk("rom_addr", 32'(rom_addr), 32'(a[7:2]));
      end

      chk("m0_rsp_valid", 32'(m0_rsp_valid), 32'(!r && pv && (pw == 0)));
      chk("m1_rsp_valid", 32'(m1_rsp_valid), 32'(!r && pv && (pw == 1)));
      if (!r && pv) begin
         exp_data = pe ? 32'h0 : rom_mem[pword];
         if (pw == 0) begin
            chk("m0_rsp_err", 32'(m0_rsp_err), 32'(pe));
            chk("m0_rsp_data", m0_rsp_data, exp_data);
         end else begin
            chk("m1_rsp_err", 32'(m1_rsp_err), 32'(pe));
            chk("m1_rsp_data", m1_rsp_data, exp_data);
         end
      end

      $display("step rst=%0b req=%0b%0b gnt=%0b%0b rd_en=%0b addr=%0d rsp=%0b%0b",
               r, q1, q0, m1_gnt, m0_gnt, rom_rd_en, rom_addr, m1_rsp_valid, m0_rsp_valid);

      @(posedge clk);

      if (r) begin
         last_w = 1;
         owner  = -1;
         pv     = 1'b0;
      end else begin
         pv    = acc;
         pw    = win;
         pe    = (a[1:0] != 2'b00);
         pword = int'(a[7:2]);
         if (acc) last_w = win;
`ifdef ROM_ARB_LOCK_EN
         if (owner >= 0) begin
            if (!((owner == 0) ? l0 : l1)) owner = -1;
         end else if (acc && ((win == 0) ? l0 : l1)) begin
            owner = win;
         end
`endif
      end
      #1;
   endtask

   initial begin
      bit         rr, q0, q1, l0, l1;
      logic [7:0] a0, a1;

      for (int i = 0; i < (1 << AW); i++) rom_mem[i] = $urandom;
      last_w = 1; owner = -1; pv = 1'b0; pw = 0; pe = 1'b0; pword = 0;
      rst = 1'b1;
      m0_req = 1'b0; m0_addr = '0; m0_lock = 1'b0;
      m1_req = 1'b0; m1_addr = '0; m1_lock = 1'b0;
      #1;

      // Reset: grants are held low even while both requesters ask.
      step(1, 1, 8'h00, 0, 1, 8'h04, 0);
      step(1, 0, 8'h00, 0, 0, 8'h00, 0);

      // Single aligned request: byte address 0x10 reads word 4.
      step(0, 1, 8'h10, 0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0, 0, 8'h00, 0);

      // Contention for four cycles straight after reset: grants m0, m1, m0, m1.
      step(1, 0, 8'h00, 0, 0, 8'h00, 0);
      step(0, 1, 8'h20, 0, 1, 8'h24, 0);
      step(0, 1, 8'h28, 0, 1, 8'h2c, 0);
      step(0, 1, 8'h30, 0, 1, 8'h34, 0);
      step(0, 1, 8'h38, 0, 1, 8'h3c, 0);
      step(0, 0, 8'h00, 0, 0, 8'h00, 0);

      // Misaligned m1 request: returns an error response with zero data.
      step(0, 0, 8'h00, 0, 1, 8'h06, 0);
      step(0, 0, 8'h00, 0, 0, 8'h00, 0);

      // Reset mid-operation: the pending m0 response is dropped, then m0 wins
      // the first tie after reset.
      step(0, 1, 8'h08, 0, 0, 8'h00, 0);
      step(1, 0, 8'h00, 0, 0, 8'h00, 0);
      step(0, 1, 8'h0c, 0, 1, 8'h14, 0);
      step(0, 1, 8'h0c, 0, 1, 8'h14, 0);
      step(0, 0, 8'h00, 0, 0, 8'h00, 0);

      // Lock: m0 locks while m1 keeps asking.
      step(0, 1, 8'h40, 1, 1, 8'h44, 0);
      step(0, 1, 8'h48, 1, 1, 8'h44, 0);
      step(0, 0, 8'h00, 0, 1, 8'h44, 0);
      step(0, 0, 8'h00, 0, 1, 8'h44, 0);
      step(0, 0, 8'h00, 0, 0, 8'h00, 0);

      // Back-to-back requests from m1 alone: words 0, 1, 2.
      step(0, 0, 8'h00, 0, 1, 8'h00, 0);
      step(0, 0, 8'h00, 0, 1, 8'h04, 0);
      step(0, 0, 8'h00, 0, 1, 8'h08, 0);
      step(0, 0, 8'h00, 0, 0, 8'h00, 0);

      // Randomized traffic.
      // Roughly 1 address in 4 is misaligned.
      // Reset is asserted occasionally.
      for (int i = 0; i < 400; i++) begin
         rr = ($urandom_range(0, 49) == 0);
         q0 = $urandom_range(0, 1);
         q1 = $urandom_range(0, 1);
         l0 = ($urandom_range(0, 3) == 0);
         l1 = ($urandom_range(0, 3) == 0);
         a0 = {6'($urandom_range(0, 63)),
               ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
         a1 = {6'($urandom_range(0, 63)),
               ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
         step(rr, q0, a0, l0, q1, a1, l1);
      end
      step(0, 0, 8'h00, 0, 0, 8'h00, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
